// File: rtl/lights_hold_ctrl.sv
// ============================================================================
// Module      : lights_hold_ctrl
// Description : Room-lighting controller. Debounces the dark sensor, turns the
//               lights on for movement in the dark and holds them on for a
//               programmable time. A force-on switch overrides movement.
//               Optional pre-off warning output built when LIGHTS_WARN_EN is
//               defined; otherwise warn is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lights_hold_ctrl #(
    parameter int HOLD_CYCLES = 16,
    parameter int DARK_FILT   = 4,
    parameter int WARN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dark,
    input  logic       movement,
    input  logic       force_on,
    output logic       turn_on_lights,
    output logic [1:0] state,
    output logic       warn
);

    localparam int c_TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_FILT_W  = (DARK_FILT > 0) ? $clog2(DARK_FILT + 1) : 1;

    localparam logic [1:0] c_ST_OFF    = 2'd0;
    localparam logic [1:0] c_ST_ON     = 2'd1;
    localparam logic [1:0] c_ST_HOLD   = 2'd2;
    localparam logic [1:0] c_ST_FORCED = 2'd3;

    localparam logic [c_TIMER_W-1:0] c_HOLD_INIT = c_TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [c_FILT_W-1:0]  c_FILT_LAST = c_FILT_W'(DARK_FILT - 1);

    // Elaboration-time guard on the legal parameter ranges.
    if (HOLD_CYCLES < 1 || DARK_FILT < 1 ||
        WARN_CYCLES < 1 || WARN_CYCLES > HOLD_CYCLES) begin : g_bad_params
        $error("lights_hold_ctrl: illegal parameter combination");
    end

    logic [1:0]           r_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic [c_FILT_W-1:0]  r_filt_cnt;
    logic                 r_dark_q;

    logic [1:0]           w_state_nxt;
    logic [c_TIMER_W-1:0] w_timer_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_OFF;
            r_timer    <= '0;
            r_filt_cnt <= '0;
            r_dark_q   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            // dark_q flips on the edge the run of differing samples reaches DARK_FILT.
            if (dark != r_dark_q) begin
                if (r_filt_cnt == c_FILT_LAST) begin
                    r_dark_q   <= ~r_dark_q;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        case (r_state)
            c_ST_OFF: begin
                if (force_on) begin
                    w_state_nxt = c_ST_FORCED;
                end else if (r_dark_q && movement) begin
                    w_state_nxt = c_ST_ON;
                end
            end
            c_ST_ON: begin
                if (force_on) begin
                    w_state_nxt = c_ST_FORCED;
                end else if (!movement) begin
                    w_state_nxt = c_ST_HOLD;
                    w_timer_nxt = c_HOLD_INIT;
                end
            end
            c_ST_HOLD: begin
                if (force_on) begin
                    w_state_nxt = c_ST_FORCED;
                end else if (movement) begin
                    w_state_nxt = c_ST_ON;
                end else if (r_timer == '0) begin
                    w_state_nxt = c_ST_OFF;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            c_ST_FORCED: begin
                if (!force_on) begin
                    w_state_nxt = c_ST_HOLD;
                    w_timer_nxt = c_HOLD_INIT;
                end
            end
            default: begin
                w_state_nxt = c_ST_OFF;
            end
        endcase
    end

    assign state          = r_state;
    assign turn_on_lights = (r_state != c_ST_OFF);

`ifdef LIGHTS_WARN_EN
    assign warn = (r_state == c_ST_HOLD) && (int'(r_timer) < WARN_CYCLES);
`else
    assign warn = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lights_hold_ctrl.sv
// ============================================================================
// Module      : tb_lights_hold_ctrl
// Description : Directed self-checking bench for lights_hold_ctrl
//               (HOLD_CYCLES=16, DARK_FILT=4, WARN_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lights_hold_ctrl;

    logic       clk;
    logic       reset;
    logic       dark;
    logic       movement;
    logic       force_on;
    logic       turn_on_lights;
    logic [1:0] state;
    logic       warn;

    int n_vec = 0;
    int n_err = 0;

`ifdef LIGHTS_WARN_EN
    localparam bit c_WARN_EN = 1'b1;
`else
    localparam bit c_WARN_EN = 1'b0;
`endif

    lights_hold_ctrl #(
        .HOLD_CYCLES (16),
        .DARK_FILT   (4),
        .WARN_CYCLES (4)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .dark           (dark),
        .movement       (movement),
        .force_on       (force_on),
        .turn_on_lights (turn_on_lights),
        .state          (state),
        .warn           (warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // st: expected state code; t: expected HOLD timer (only meaningful in HOLD)
    task automatic expect_st(input string tag, input int st, input int t);
        logic exp_w;
        exp_w = c_WARN_EN && (st == 2) && (t < 4);
        chk({tag, "_state"}, {6'd0, state}, 8'(st));
        chk({tag, "_lights"}, {7'd0, turn_on_lights}, (st != 0) ? 8'd1 : 8'd0);
        chk({tag, "_warn"}, {7'd0, warn}, {7'd0, exp_w});
    endtask

    initial begin
        int cnt;
        reset    = 1'b1;
        dark     = 1'b0;
        movement = 1'b0;
        force_on = 1'b0;
        tick(2);
        expect_st("reset", 0, 0);
        reset = 1'b0;

        // 1: dark filter needs 4 samples before movement is honoured
        dark = 1'b1;
        tick(3);
        expect_st("dark3", 0, 0);
        movement = 1'b1;
        tick(1);
        expect_st("dark4_mov", 0, 0);
        tick(1);
        expect_st("on", 1, 0);

        // 2: HOLD for 16 cycles, dark dropping meanwhile is ignored
        movement = 1'b0;
        dark     = 1'b0;
        tick(1);
        expect_st("hold_t15", 2, 15);
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            expect_st($sformatf("hold_t%0d", 15 - k), 2, 15 - k);
        end
        tick(1);
        expect_st("hold_expired", 0, 0);

        // 3a: movement exactly when timer is 0 re-enters ON
        dark = 1'b1;
        tick(4);
        expect_st("redark", 0, 0);
        movement = 1'b1;
        tick(1);
        expect_st("on2", 1, 0);
        movement = 1'b0;
        tick(16);
        expect_st("hold2_t0", 2, 0);
        movement = 1'b1;
        tick(1);
        expect_st("mov_at_t0", 1, 0);

        // 3b: movement pulse at timer=5 restarts a full 16-cycle HOLD
        movement = 1'b0;
        tick(11);
        expect_st("hold3_t5", 2, 5);
        movement = 1'b1;
        tick(1);
        expect_st("pulse_on", 1, 0);
        movement = 1'b0;
        tick(1);
        expect_st("hold4_t15", 2, 15);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (state == 2'd2) cnt++;
            else break;
        end
        chk("hold_len", 8'(cnt), 8'd16);
        expect_st("hold4_off", 0, 0);

        // 4: force_on overrides without darkness and beats movement
        dark = 1'b0;
        tick(4);
        movement = 1'b1;
        tick(1);
        expect_st("light_mov", 0, 0);
        force_on = 1'b1;
        tick(1);
        expect_st("forced", 3, 0);
        tick(1);
        expect_st("forced_mov", 3, 0);
        force_on = 1'b0;
        movement = 1'b0;
        tick(1);
        expect_st("fhold_t15", 2, 15);
        tick(15);
        expect_st("fhold_t0", 2, 0);
        tick(1);
        expect_st("fhold_off", 0, 0);

        // 5: reset mid-HOLD and mid-FORCED, filter restarts from zero
        force_on = 1'b1;
        tick(1);
        force_on = 1'b0;
        tick(9);
        expect_st("rhold_t7", 2, 7);
        reset = 1'b1;
        tick(1);
        expect_st("rst_hold", 0, 0);
        reset    = 1'b0;
        force_on = 1'b1;
        tick(1);
        expect_st("forced2", 3, 0);
        reset = 1'b1;
        tick(1);
        expect_st("rst_forced", 0, 0);
        reset    = 1'b0;
        force_on = 1'b0;
        dark     = 1'b1;
        movement = 1'b1;
        tick(4);
        expect_st("post_rst_dark4", 0, 0);
        tick(1);
        expect_st("post_rst_on", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
